profile_counter_bank: RTL
=========================

# profile_counter_bank

Multi-channel event profiling counter bank: the parametrised successor of the single up/down counter. It provides CHANNELS independent WIDTH-bit counters, each with start/stop run control, per-channel direction, per-channel clear, a wrap or saturate overflow policy, and sticky overflow flags. An atomic snapshot copies every channel into shadow registers, which a software-facing reader accesses through an indexed, registered read port. The block sits between event sources (pipeline stalls, bus transactions, ISR entries) and the CPU-visible profiling register file.

## Interface
- WIDTH, 32: counter width in bits, at least 2.
- CHANNELS, 4: number of counter channels, at least 1.
- IDX_WIDTH, 2: width of readIndex. Must satisfy CHANNELS <= 2**IDX_WIDTH.
- SATURATE, 0: overflow policy for all channels. 0 = wrap; 1 = clamp at the limit.

Ports (reset: reset, synchronous, active-high; clock: clock):
- clock  in  1  system clock; everything updates on the rising edge.
- reset  in  1  synchronous, active-high; sets all state to reset values.
- start  in  CHANNELS  per-channel pulse; sets the run bit.
- stop  in  CHANNELS  per-channel pulse; clears the run bit.
- clear  in  CHANNELS  per-channel pulse; zeroes the counter and its overflow flag.
- direction  in  CHANNELS  per channel: 1 = count up, 0 = count down.
- countEvent  in  CHANNELS  per-channel event qualifier; one count per cycle while high.
- snapshot  in  1  pulse; atomically copies all counters and overflow flags into the shadow registers.
- readIndex  in  IDX_WIDTH  selects the shadow channel to read.
- readValue  out  WIDTH  registered shadow counter of the selected channel.
- readOverflow  out  1  registered shadow overflow flag of the selected channel.
- running  out  CHANNELS  run bit per channel.
- overflow  out  CHANNELS  live sticky overflow/underflow flag per channel.

## Operation
- Per-channel state is one run bit with two states, IDLE (0) and RUNNING (1).
  - start[i] moves IDLE to RUNNING.
  - stop[i] moves RUNNING to IDLE.
  - If start[i] and stop[i] are high in the same cycle, stop wins and the next state is IDLE.
- Count condition: running[i] is 1 (the registered value before the edge) and countEvent[i] is 1.
  - An event in the start cycle is not counted.
  - An event in the stop cycle is counted.
- Counter update priority, per channel: clear, then count, then hold.
  - clear[i] forces the counter to 0 and overflow[i] to 0, regardless of countEvent.
  - clear does not change the run bit.
- Up count: value+1.
  - At all-ones with SATURATE=0, the counter wraps to 0 and sets overflow[i].
  - At all-ones with SATURATE=1, the counter holds all-ones and sets overflow[i].
- Down count: value-1.
  - At 0 with SATURATE=0, the counter wraps to all-ones and sets overflow[i].
  - At 0 with SATURATE=1, the counter holds 0 and sets overflow[i].
- overflow[i] is sticky. Only clear[i] or reset clears it.
- Channels are fully independent; any combination of simultaneous per-channel events is legal.
- Snapshot: on snapshot=1, every shadow counter and shadow flag loads the pre-edge live value.
  - A same-cycle clear or count is not reflected in the shadow.
  - Shadows hold their values until the next snapshot or reset.
- Read port: readValue and readOverflow register the shadow entry at readIndex every cycle.
  - For readIndex >= CHANNELS, both outputs register 0.

## Timing
- Reset values: all counters 0, running 0, overflow 0, all shadows 0, readValue 0, readOverflow 0.
- Reset overrides every other input in the same cycle.
- Counter latency: an event sampled at edge N is visible on the counter at edge N.
- Run control latency: start sampled at edge N enables counting of events sampled at edge N+1 and later.
- Snapshot to read: snapshot at edge N; readValue reflects it from edge N+1 (readIndex held constant).
- Read latency: a readIndex change is visible on readValue after 1 cycle.
- Reset mid-run: all channels return to IDLE with zero count. Events in the reset cycle are dropped.

## Test plan
- Parameters WIDTH=8, CHANNELS=4 for all scenarios unless noted.
- Reset, start ch0 with direction=1, 5 events, snapshot, readIndex=0 -> readValue=5, running=4'b0001, overflow=0.
- Start ch1 with direction=0, 3 events -> count 253, overflow[1]=1. Then clear[1] -> count 0, overflow[1]=0, running[1] still 1.
- SATURATE=1, ch2 up-counted 260 events -> count 255, overflow[2]=1. Then 1 down event -> count 254, overflow[2] still 1.
- Start and stop on ch3 in the same cycle -> running[3]=0. Event in the start cycle of ch0 -> not counted. Event in the stop cycle -> counted.
- ch0 at 9, snapshot with event and clear both in the same cycle -> shadow 9, live 0. readIndex=0 -> readValue=9. readIndex=3 at CHANNELS=3 -> readValue=0.
- Reset asserted while ch0-3 running at nonzero counts -> all outputs 0 on the next cycle, and events during reset are ignored.

Source files
------------

// File: rtl/profile_counter_bank.sv
// Multi-channel profiling counter bank: per-channel run control, up/down counting with
// wrap or saturate policy, sticky overflow flags, atomic snapshot and a registered read port.
module profile_counter_bank #(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 4,
  parameter int IDX_WIDTH = 2,
  parameter int SATURATE  = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [CHANNELS-1:0]  start,
  input  logic [CHANNELS-1:0]  stop,
  input  logic [CHANNELS-1:0]  clear,
  input  logic [CHANNELS-1:0]  direction,
  input  logic [CHANNELS-1:0]  countEvent,
  input  logic                 snapshot,
  input  logic [IDX_WIDTH-1:0] readIndex,
  output logic [WIDTH-1:0]     readValue,
  output logic                 readOverflow,
  output logic [CHANNELS-1:0]  running,
  output logic [CHANNELS-1:0]  overflow
);

  typedef enum logic {IDLE = 1'b0, RUNNING = 1'b1} runState_t;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  runState_t           runState [CHANNELS];
  runState_t           runNext  [CHANNELS];
  logic [WIDTH-1:0]    count       [CHANNELS];
  logic [WIDTH-1:0]    countNext   [CHANNELS];
  logic [WIDTH-1:0]    shadowCount [CHANNELS];
  logic [CHANNELS-1:0] ovfNext;
  logic [CHANNELS-1:0] shadowOvf;
  logic [WIDTH-1:0]    readMux;
  logic                readOvfMux;

  // Run-bit next state: stop dominates a simultaneous start.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      runNext[i] = runState[i];
      if (stop[i]) begin
        runNext[i] = IDLE;
      end else if (start[i]) begin
        runNext[i] = RUNNING;
      end
      running[i] = (runState[i] == RUNNING);
    end
  end

  // Counting uses the pre-edge run bit, so a start-cycle event is dropped and a stop-cycle event counts.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      countNext[i] = count[i];
      ovfNext[i]   = overflow[i];
      if (clear[i]) begin
        countNext[i] = '0;
        ovfNext[i]   = 1'b0;
      end else if (runState[i] == RUNNING && countEvent[i]) begin
        if (direction[i]) begin
          if (count[i] == ALL_ONES) begin
            ovfNext[i]   = 1'b1;
            countNext[i] = (SATURATE != 0) ? ALL_ONES : '0;
          end else begin
            countNext[i] = count[i] + WIDTH'(1);
          end
        end else begin
          if (count[i] == '0) begin
            ovfNext[i]   = 1'b1;
            countNext[i] = (SATURATE != 0) ? '0 : ALL_ONES;
          end else begin
            countNext[i] = count[i] - WIDTH'(1);
          end
        end
      end
    end
  end

  // Out-of-range indices fall through to zero.
  always_comb begin
    readMux    = '0;
    readOvfMux = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (readIndex == IDX_WIDTH'(i)) begin
        readMux    = shadowCount[i];
        readOvfMux = shadowOvf[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        runState[i]    <= IDLE;
        count[i]       <= '0;
        shadowCount[i] <= '0;
      end
      overflow     <= '0;
      shadowOvf    <= '0;
      readValue    <= '0;
      readOverflow <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        runState[i] <= runNext[i];
        count[i]    <= countNext[i];
        if (snapshot) begin
          shadowCount[i] <= count[i];
        end
      end
      overflow <= ovfNext;
      if (snapshot) begin
        shadowOvf <= overflow;
      end
      readValue    <= readMux;
      readOverflow <= readOvfMux;
    end
  end

endmodule
